serial_addsub: RTL and testbench

- Bit-serial two's-complement adder/subtractor: one full-adder cell plus a carry flip-flop, processing LSB first, one bit per clock.
- Companion to the parallel ripple adder. It performs the reverse operation, A-B, as well as A+B, and trades latency for area.
- Sits behind a start/done handshake so a controller or bench can issue back-to-back operations.

---
 rtl/serial_addsub.sv | 123 ++++++++++++
 tb/tb_serial_addsub.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, LSB first, one bit per clock.
// Ports: clk, rst_n (sync, active-low), start/sub/a/b in; busy/done/result/carry/overflow out.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PENULT = CNT_W'(WIDTH - 2);

  state_t           r_state;
  state_t           w_next;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cff;
  logic             r_cmsb;
  logic             r_carry;
  logic             r_ovf;

  logic             w_run;
  logic             w_accept;
  logic             w_last;
  logic             w_penult;
  logic             w_s;
  logic             w_co;

  assign w_run    = (r_state == S_RUN);
  assign w_accept = !w_run && start;
  assign w_last   = (r_cnt == LAST);
  assign w_penult = (r_cnt == PENULT);

  // The single full-adder cell.
  assign w_s  = r_sa[0] ^ r_sb[0] ^ r_cff;
  assign w_co = (r_sa[0] & r_sb[0])
              | (r_sa[0] & r_cff)
              | (r_sb[0] & r_cff);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // busy/done come straight from flops so no input reaches an output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_RUN);
      r_done  <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_cff    <= 1'b0;
      r_cmsb   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      // Subtract as a + ~b + 1: the +1 rides in on the carry flop.
      r_sa  <= a;
      r_sb  <= sub ? ~b : b;
      r_cff <= sub;
      r_cnt <= '0;
    end else if (w_run) begin
      r_acc <= {w_s, r_acc[WIDTH-1:1]};
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_cff <= w_co;
      r_cnt <= r_cnt + 1'b1;
      // Carry out of bit WIDTH-2 is the carry into the MSB.
      if (w_penult) r_cmsb <= w_co;
      if (w_last) begin
        r_result <= {w_s, r_acc[WIDTH-1:1]};
        r_carry  <= w_co;
        r_ovf    <= w_co ^ r_cmsb;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign carry    = r_carry;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: directed vectors, reset abort,
// back-to-back, ignored start, and boundary-operand sweeps.
module tb_serial_addsub;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       v;
    int         cyc;
    int         id;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] r;
    logic       c;
    logic       v;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry;
  logic       overflow;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   blen = 0;
  int   op_id = 0;
  int   rst_chk_a = -1;
  int   rst_chk_b = -1;
  int   end_cyc = -1;
  exp_t sb[$];
  exp_t mon_e;

  serial_addsub #(.WIDTH(WIDTH), .CNT_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sign-rule reference used for the sweeps.
  function automatic exp_t model(input logic [7:0] x,
                                 input logic [7:0] y,
                                 input logic s);
    exp_t m;
    logic [8:0] t;
    logic [7:0] yy;
    yy = s ? ~y : y;
    t = {1'b0, x} + {1'b0, yy} + {8'd0, s};
    m.r = t[7:0];
    m.c = t[8];
    if (s) m.v = (x[7] != y[7]) && (t[7] != x[7]);
    else   m.v = (x[7] == y[7]) && (t[7] != x[7]);
    m.cyc = 0;
    m.id = 0;
    return m;
  endfunction

  // Drive one op, push its expectation, then ride out the RUN phase.
  // With junk set, start stays high with scrambled operands during RUN.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                       input logic is, input logic [7:0] er,
                       input logic ec, input logic ev, input bit junk);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    a = ia;
    b = ib;
    sub = is;
    @(posedge clk);
    #1;
    e.r = er;
    e.c = ec;
    e.v = ev;
    e.cyc = cyc + WIDTH;
    e.id = op_id;
    op_id++;
    sb.push_back(e);
    for (int k = 0; k < WIDTH; k++) begin
      @(negedge clk);
      if (junk) begin
        a = 8'($urandom);
        b = 8'($urandom);
        sub = ~sub;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done cyc=%0d result=%h carry=%b ovf=%b",
                 cyc, result, carry, overflow);
      end else begin
        mon_e = sb.pop_front();
        if (result !== mon_e.r || carry !== mon_e.c ||
            overflow !== mon_e.v || cyc != mon_e.cyc || blen != WIDTH) begin
          fails++;
          $display("FAIL op%0d got result=%h carry=%b ovf=%b cyc=%0d busy_len=%0d want result=%h carry=%b ovf=%b cyc=%0d busy_len=%0d",
                   mon_e.id, result, carry, overflow, cyc, blen,
                   mon_e.r, mon_e.c, mon_e.v, mon_e.cyc, WIDTH);
        end
      end
      blen = 0;
    end else if (busy) begin
      blen++;
    end else begin
      blen = 0;
    end
    if (cyc == rst_chk_a || cyc == rst_chk_b) begin
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 ||
          carry !== 1'b0 || overflow !== 1'b0) begin
        fails++;
        $display("FAIL reset_state cyc=%0d got busy=%b done=%b result=%h carry=%b ovf=%b want all 0",
                 cyc, busy, done, result, carry, overflow);
      end
    end
    if (cyc == end_cyc) begin
      tests++;
      if (sb.size() != 0) begin
        fails++;
        $display("FAIL drain_timeout got %0d pending want 0", sb.size());
      end
    end
  end

  vec_t dir[10];
  logic [7:0] edge_v[5];

  initial begin
    exp_t m;
    logic [7:0] xa;
    logic [7:0] xb;

    dir[0] = '{8'd23, 8'd42, 1'b0, 8'd65, 1'b0, 1'b0};
    dir[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    dir[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    dir[3] = '{8'd5,  8'd9,  1'b1, 8'hFC, 1'b0, 1'b0};
    dir[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    dir[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    dir[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    dir[7] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
    dir[8] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    dir[9] = '{8'h55, 8'h0F, 1'b0, 8'h64, 1'b0, 1'b0};
    edge_v[0] = 8'h00;
    edge_v[1] = 8'h01;
    edge_v[2] = 8'h7F;
    edge_v[3] = 8'h80;
    edge_v[4] = 8'hFF;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_chk_a = cyc;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      issue(dir[i].a, dir[i].b, dir[i].s,
            dir[i].r, dir[i].c, dir[i].v, (i % 2) == 1);
    idle(3);

    @(negedge clk);
    start = 1'b1;
    a = 8'h55;
    b = 8'h0F;
    sub = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_chk_b = cyc;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2 * WIDTH);

    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int s = 0; s < 2; s++) begin
          m = model(edge_v[i], edge_v[j], s[0]);
          issue(edge_v[i], edge_v[j], s[0], m.r, m.c, m.v, 1'b0);
        end
    idle(2);

    for (int i = 0; i < 64; i++) begin
      xa = 8'(i * 37 + 11);
      xb = 8'(i * 91 + 5);
      m = model(xa, xb, i[0]);
      issue(xa, xb, i[0], m.r, m.c, m.v, (i % 3) == 0);
    end
    idle(1);

    end_cyc = cyc + 40;
    repeat (42) @(negedge clk);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
